dmem_arbiter: RTL

Sequencing controller and arbiter for the byte-organised data memory. It shares one 8-bit synchronous memory port between two 16-bit requesters: port 0 is the pipeline MEM stage and port 1 is the program/data loader. Each 16-bit access is split into one or two byte cycles, little-endian. Load results are returned zero- or sign-extended per the access size.

---
 rtl/dmem_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one 8-bit synchronous data-memory port between the
//            pipeline MEM stage (port 0) and the loader (port 1). Each 16-bit
//            access is split into little-endian byte cycles; loads are
//            zero/sign-extended per access size.
// Config   : DMEM_ARB_RR_EN - round-robin arbitration when defined,
//            fixed priority (port 0 first) otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic              p1_req,
   input  logic              p0_we,
   input  logic              p1_we,
   input  logic [1:0]        p0_size,
   input  logic [1:0]        p1_size,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [15:0]       p0_wdata,
   input  logic [15:0]       p1_wdata,
   output logic              p0_ack,
   output logic              p1_ack,
   output logic [15:0]       p0_rdata,
   output logic [15:0]       p1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              grant
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ACC0 = 3'd1,
      S_ACC1 = 3'd2,
      S_FIN  = 3'd3,
      S_RESP = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_grant;
   logic              r_we;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_wdata;
   logic [7:0]        r_lo;
   logic [15:0]       r_p0_rdata;
   logic [15:0]       r_p1_rdata;
   logic              r_p0_ack;
   logic              r_p1_ack;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [7:0]        r_mem_wdata;

   logic              w_any;
   logic              w_pick;
   logic              w_sel_we;
   logic [1:0]        w_sel_size;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [15:0]       w_sel_wdata;
   logic              w_word;
   logic [15:0]       w_load_val;

   assign w_any       = p0_req | p1_req;
   assign w_sel_we    = w_pick ? p1_we    : p0_we;
   assign w_sel_size  = w_pick ? p1_size  : p0_size;
   assign w_sel_addr  = w_pick ? p1_addr  : p0_addr;
   assign w_sel_wdata = w_pick ? p1_wdata : p0_wdata;
   // size 11 behaves as a word access
   assign w_word      = (r_size == 2'b00) || (r_size == 2'b11);

`ifdef DMEM_ARB_RR_EN
   logic r_last;

   // Winner on contention is the port not served last; lone requester wins
   always_comb begin
      w_pick = p1_req;
      if (p0_req && p1_req) w_pick = ~r_last;
   end

   // Last-served port, updated on every grant; reset value favours port 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_last <= 1'b1;
      else if (r_state == S_IDLE && w_any) r_last <= w_pick;
   end
`else
   // Fixed priority: port 1 wins only while port 0 is not requesting
   always_comb w_pick = ~p0_req;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state sequencing: one byte cycle for bytes, two for words
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_state_nxt = S_ACC0;
         S_ACC0:  w_state_nxt = w_word ? S_ACC1 : S_FIN;
         S_ACC1:  w_state_nxt = S_FIN;
         S_FIN:   w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Latch the winning request for the whole transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant <= 1'b0;
         r_we    <= 1'b0;
         r_size  <= 2'b00;
         r_addr  <= '0;
         r_wdata <= 16'h0000;
      end else if (r_state == S_IDLE && w_any) begin
         r_grant <= w_pick;
         r_we    <= w_sel_we;
         r_size  <= w_sel_size;
         r_addr  <= w_sel_addr;
         r_wdata <= w_sel_wdata;
      end
   end

   // Registered memory command for the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 8'h00;
      end else begin
         case (w_state_nxt)
            S_ACC0: begin
               // ACC0 is only entered from IDLE, so the request is not latched yet
               r_mem_en    <= 1'b1;
               r_mem_we    <= w_sel_we;
               r_mem_addr  <= w_sel_addr;
               r_mem_wdata <= w_sel_wdata[7:0];
            end
            S_ACC1: begin
               r_mem_en    <= 1'b1;
               r_mem_we    <= r_we;
               r_mem_addr  <= r_addr + ADDR_W'(1);
               r_mem_wdata <= r_wdata[15:8];
            end
            default: begin
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
            end
         endcase
      end
   end

   // Final load value formed from the last returned byte and the saved low byte
   always_comb begin
      w_load_val = {mem_rdata, r_lo};
      case (r_size)
         2'b01:   w_load_val = {8'h00, mem_rdata};
         2'b10:   w_load_val = {{8{mem_rdata[7]}}, mem_rdata};
         default: w_load_val = {mem_rdata, r_lo};
      endcase
   end

   // Capture read bytes; only loads update the granted port's result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lo       <= 8'h00;
         r_p0_rdata <= 16'h0000;
         r_p1_rdata <= 16'h0000;
      end else begin
         if (r_state == S_ACC1 && !r_we) r_lo <= mem_rdata;
         if (r_state == S_FIN && !r_we) begin
            if (r_grant) r_p1_rdata <= w_load_val;
            else         r_p0_rdata <= w_load_val;
         end
      end
   end

   // One-cycle ack pulse, high during RESP on the granted port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p0_ack <= 1'b0;
         r_p1_ack <= 1'b0;
      end else begin
         r_p0_ack <= (r_state == S_FIN) && !r_grant;
         r_p1_ack <= (r_state == S_FIN) &&  r_grant;
      end
   end

   assign p0_ack    = r_p0_ack;
   assign p1_ack    = r_p1_ack;
   assign p0_rdata  = r_p0_rdata;
   assign p1_rdata  = r_p1_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = (r_state != S_IDLE);
   assign grant     = r_grant;

endmodule
`default_nettype wire
